// File: rtl/apple2_disk_pkg.sv
// -----------------------------------------------------------------------------
// apple2_disk_pkg
// Shared definitions for the nibble-track <-> SD-card synchroniser.
//   state_t                    : policy FSM states (IDLE / FLUSH / LOAD)
//   SECTOR_BYTES               : bytes per SD sector
//   SECTORS_PER_TRACK_DEFAULT  : SD sectors holding one nibble track
// -----------------------------------------------------------------------------
package apple2_disk_pkg;

    localparam int unsigned SECTOR_BYTES              = 512;
    localparam int unsigned SECTORS_PER_TRACK_DEFAULT = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/sd_sector_seq.sv
// -----------------------------------------------------------------------------
// sd_sector_seq
// Runs one multi-sector SD transfer covering a whole nibble track.
// Ports:
//   clk_sys, reset_n  : clock, asynchronous active-low reset
//   start_i           : one-cycle pulse, begins a transfer of track_i
//   wr_i              : with start_i, 1 = write (flush), 0 = read (load)
//   track_i           : track whose sectors are transferred
//   sd_ack_i          : SD host acknowledge, high for one sector
//   sd_lba_o          : current sector address
//   sd_rd_o, sd_wr_o  : request lines (mutually exclusive)
//   track_sec_o       : sector index within the track (track-RAM upper bits)
//   done_o            : one-cycle pulse, the last sector has finished
//
// Handshake: a request line (sd_rd_o / sd_wr_o) stays high for the whole
// track. Each sector is one high pulse of sd_ack_i; its rising edge advances
// sd_lba_o, its falling edge advances track_sec_o. On the rising edge of the
// last sector's ack the request line drops, so the host sees no further
// request and the falling edge of that ack marks completion.
// -----------------------------------------------------------------------------
module sd_sector_seq
    import apple2_disk_pkg::*;
#(
    parameter int unsigned SECTORS_PER_TRACK = SECTORS_PER_TRACK_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic [5:0]  track_i,
    input  logic        sd_ack_i,
    output logic [31:0] sd_lba_o,
    output logic        sd_rd_o,
    output logic        sd_wr_o,
    output logic [3:0]  track_sec_o,
    output logic        done_o
);

    localparam logic [31:0] SPT_32    = 32'(SECTORS_PER_TRACK);
    localparam logic [3:0]  SEC_LAST  = 4'(SECTORS_PER_TRACK - 1);
    localparam logic [3:0]  SEC_COUNT = 4'(SECTORS_PER_TRACK);

    logic        ack_q;
    logic        active_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] lba_q;
    logic [3:0]  sec_q;

    logic        ack_rise;
    logic        ack_fall;
    logic        req_on;
    logic [31:0] lba_base;

    // Edges are taken against a registered copy of the ack, so outputs move
    // one cycle after the host's ack edge.
    assign ack_rise = sd_ack_i & ~ack_q;
    assign ack_fall = ~sd_ack_i & ack_q;
    assign req_on   = rd_q | wr_q;

    // Full 32-bit product: 13 * 63 is far below 2^32, so nothing is lost.
    assign lba_base = SPT_32 * {26'd0, track_i};

    // Completion: the last ack fell after its request line was already dropped.
    assign done_o = ack_fall & active_q & ~req_on;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_q    <= 1'b0;
            active_q <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            lba_q    <= 32'd0;
            sec_q    <= 4'd0;
        end else begin
            ack_q <= sd_ack_i;
            if (start_i) begin
                lba_q    <= lba_base;
                sec_q    <= 4'd0;
                rd_q     <= ~wr_i;
                wr_q     <= wr_i;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (ack_rise && req_on) begin
                    lba_q <= lba_q + 32'd1;
                    if (sec_q == SEC_LAST) begin
                        rd_q <= 1'b0;
                        wr_q <= 1'b0;
                    end
                end
                if (ack_fall) begin
                    // Saturate so a stray extra ack cannot walk past the track.
                    if (sec_q != SEC_COUNT) begin
                        sec_q <= sec_q + 4'd1;
                    end
                    if (!req_on) begin
                        active_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign sd_lba_o    = lba_q;
    assign sd_rd_o     = rd_q;
    assign sd_wr_o     = wr_q;
    assign track_sec_o = sec_q;

endmodule

// File: rtl/disk_track_sync.sv
// -----------------------------------------------------------------------------
// disk_track_sync
// Keeps the nibble-track RAM in step with the disk image on SD: loads the
// selected track, writes a modified track back before leaving it, and
// reloads after an image remount. The sector handshake lives in sd_sector_seq.
// Ports:
//   clk_sys, reset_n       : clock, asynchronous active-low reset
//   track                  : track selected by the disk controller
//   img_mounted            : one-cycle pulse on (re)mount
//   img_size               : image size in bytes, 0 = no image
//   write_protect          : high -> track writes never mark dirty
//   track_ram_we           : controller wrote a byte into track RAM
//   sd_lba, sd_rd, sd_wr   : SD request
//   sd_ack                 : SD host acknowledge (one pulse per sector)
//   track_sec              : sector index during a transfer
//   cpu_wait               : stalls the CPU during flush/load
//   busy                   : FSM not in IDLE
//   dbg_state              : current FSM state
// -----------------------------------------------------------------------------
module disk_track_sync
    import apple2_disk_pkg::*;
#(
    parameter int unsigned SECTORS_PER_TRACK = SECTORS_PER_TRACK_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [5:0]  track,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic        write_protect,
    input  logic        track_ram_we,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [3:0]  track_sec,
    output logic        cpu_wait,
    output logic        busy,
    output state_t      dbg_state
);

    state_t     state_q;
    logic [5:0] cur_track_q;
    logic       dirty_q;
    logic       pending_q;
    logic       cpu_wait_q;

    logic       has_img;
    logic       seq_start;
    logic       seq_wr;
    logic [5:0] seq_track;
    logic       seq_done;

    assign has_img = (img_size != 64'd0);

    // Transfer launch decision. A flush always targets the track being left;
    // every load targets the track currently selected.
    always_comb begin
        seq_start = 1'b0;
        seq_wr    = 1'b0;
        seq_track = track;
        case (state_q)
            ST_IDLE: begin
                if (has_img) begin
                    if (pending_q) begin
                        seq_start = 1'b1;
                    end else if (track != cur_track_q) begin
                        seq_start = 1'b1;
                        if (dirty_q) begin
                            seq_wr    = 1'b1;
                            seq_track = cur_track_q;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Flush finished: chain straight into loading the new track.
                seq_start = seq_done;
            end
            default: begin
                seq_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cur_track_q <= 6'h3F;
            dirty_q     <= 1'b0;
            pending_q   <= 1'b0;
            cpu_wait_q  <= 1'b0;
        end else begin
            if (img_mounted) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!has_img) begin
                        cur_track_q <= track;
                        dirty_q     <= 1'b0;
                        pending_q   <= 1'b0;
                    end else if (seq_start) begin
                        cpu_wait_q <= 1'b1;
                        if (seq_wr) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            // A load discards local edits and satisfies any
                            // remount seen so far; a new pulse this very
                            // cycle still counts.
                            state_q     <= ST_LOAD;
                            cur_track_q <= track;
                            dirty_q     <= 1'b0;
                            pending_q   <= img_mounted;
                        end
                    end else if (track_ram_we && !write_protect) begin
                        dirty_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (seq_done) begin
                        state_q     <= ST_LOAD;
                        cur_track_q <= track;
                        dirty_q     <= 1'b0;
                        pending_q   <= img_mounted;
                    end
                end
                ST_LOAD: begin
                    if (seq_done) begin
                        state_q    <= ST_IDLE;
                        cpu_wait_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sd_sector_seq #(
        .SECTORS_PER_TRACK (SECTORS_PER_TRACK)
    ) u_seq (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .start_i     (seq_start),
        .wr_i        (seq_wr),
        .track_i     (seq_track),
        .sd_ack_i    (sd_ack),
        .sd_lba_o    (sd_lba),
        .sd_rd_o     (sd_rd),
        .sd_wr_o     (sd_wr),
        .track_sec_o (track_sec),
        .done_o      (seq_done)
    );

    assign cpu_wait  = cpu_wait_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_disk_track_sync.sv
module tb_disk_track_sync;
    import apple2_disk_pkg::*;

    localparam int SPT = 13;
    localparam logic [63:0] IMG_BYTES = 64'd143360;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [5:0]  track;
    logic        img_mounted;
    logic [63:0] img_size;
    logic        write_protect;
    logic        track_ram_we;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [3:0]  track_sec;
    logic        cpu_wait;
    logic        busy;
    state_t      dbg_state;

    always #5 clk_sys = ~clk_sys;

    disk_track_sync dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .track         (track),
        .img_mounted   (img_mounted),
        .img_size      (img_size),
        .write_protect (write_protect),
        .track_ram_we  (track_ram_we),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .track_sec     (track_sec),
        .cpu_wait      (cpu_wait),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];   // {is_write, lba} per sector, in order

    int cyc = 0;
    int ack_cnt = 0;
    int wr_acks = 0;
    int last_fall_cyc = 0;
    int cw_fall_cyc = 0;
    int cw_falls = 0;
    bit host_en = 1'b0;
    logic cw_prev = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (cw_prev && !cpu_wait) begin
            cw_falls++;
            cw_fall_cyc = cyc;
        end
        cw_prev = cpu_wait;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int m_cur;
    bit m_dirty;
    bit m_pending;

    task automatic push_op(input bit wr, input int trk);
        for (int i = 0; i < SPT; i++) exp_q.push_back({wr, 32'(SPT * trk + i)});
    endtask

    // Outcome of the sync policy once the selected track/image settle.
    task automatic model_settle(input int trk, input bit has_img);
        if (!has_img) begin
            m_cur = trk; m_dirty = 0; m_pending = 0;
        end else if (m_pending) begin
            push_op(1'b0, trk);
            m_cur = trk; m_dirty = 0; m_pending = 0;
        end else if (trk != m_cur) begin
            if (m_dirty) push_op(1'b1, m_cur);
            push_op(1'b0, trk);
            m_cur = trk; m_dirty = 0;
        end
    endtask

    // ---------------- SD host responder ----------------
    initial begin : sd_host
        logic [32:0] e;
        sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            if (host_en && (sd_rd || sd_wr)) begin
                check_eq("rd_wr_exclusive", {63'd0, sd_rd & sd_wr}, 64'd0);
                check_eq("cpu_wait_in_xfer", {63'd0, cpu_wait}, 64'd1);
                check_eq("xfer_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("xfer_kind_lba", {31'd0, sd_wr, sd_lba}, {31'd0, e});
                end
                if (sd_wr) wr_acks++;
                ack_cnt++;
                sd_ack = 1'b1;
                repeat (2) @(posedge clk_sys);
                #1 sd_ack = 1'b0;
                last_fall_cyc = cyc;
                @(posedge clk_sys);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys); #2;
    endtask

    task automatic set_track(input int t);
        tick();
        track = 6'(t);
        model_settle(t, img_size != 0);
    endtask

    task automatic pulse_we(input bit wp);
        write_protect = wp;
        track_ram_we = 1'b1;
        if (!wp) m_dirty = 1;
        model_settle(int'(track), img_size != 0);
        tick();
        track_ram_we = 1'b0;
    endtask

    task automatic pulse_mount();
        img_mounted = 1'b1;
        m_pending = 1;
        model_settle(int'(track), img_size != 0);
        tick();
        img_mounted = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int stable = 0;
        int n = 0;
        repeat (3) @(posedge clk_sys);
        while (stable < 4 && n < 3000) begin
            @(negedge clk_sys);
            n++;
            if (!busy && !sd_ack && exp_q.size() == 0) stable++;
            else stable = 0;
        end
        check_eq({tag, "_settled"}, {63'd0, stable >= 4}, 64'd1);
        check_eq({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_acks(input int target, input string tag);
        int n = 0;
        while (ack_cnt < target && n < 1000) begin
            tick();
            n++;
        end
        check_eq({tag, "_reached"}, {63'd0, ack_cnt >= target}, 64'd1);
    endtask

    // ---------------- main sequence ----------------
    int a0, w0, f0;

    initial begin : main
        reset_n = 1'b0;
        track = 6'd0;
        img_mounted = 1'b0;
        img_size = IMG_BYTES;
        write_protect = 1'b0;
        track_ram_we = 1'b0;
        m_cur = 63; m_dirty = 0; m_pending = 0;

        repeat (3) @(posedge clk_sys);
        #1;
        check_eq("rst_sd_rd", {63'd0, sd_rd}, 64'd0);
        check_eq("rst_sd_wr", {63'd0, sd_wr}, 64'd0);
        check_eq("rst_cpu_wait", {63'd0, cpu_wait}, 64'd0);
        check_eq("rst_sd_lba", {32'd0, sd_lba}, 64'd0);
        check_eq("rst_track_sec", {60'd0, track_sec}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);

        // Initial load of track 0
        host_en = 1'b1;
        a0 = ack_cnt; w0 = wr_acks;
        model_settle(0, 1'b1);
        @(negedge clk_sys) reset_n = 1'b1;
        wait_idle("initial_load");
        check_eq("init_acks", 64'(ack_cnt - a0), 64'd13);
        check_eq("init_track_sec", {60'd0, track_sec}, 64'd13);
        check_eq("init_cpu_wait_lag", 64'(cw_fall_cyc - last_fall_cyc), 64'd1);
        check_eq("init_no_wr", 64'(wr_acks - w0), 64'd0);

        // Clean step 0 -> 5
        a0 = ack_cnt; w0 = wr_acks;
        set_track(5);
        wait_idle("clean_step");
        check_eq("clean_acks", 64'(ack_cnt - a0), 64'd13);
        check_eq("clean_no_wr", 64'(wr_acks - w0), 64'd0);

        // Dirty step 5 -> 6: flush then load, cpu_wait held throughout
        a0 = ack_cnt; w0 = wr_acks; f0 = cw_falls;
        pulse_we(1'b0);
        set_track(6);
        wait_idle("dirty_step");
        check_eq("dirty_acks", 64'(ack_cnt - a0), 64'd26);
        check_eq("dirty_wr_acks", 64'(wr_acks - w0), 64'd13);
        check_eq("dirty_cpu_wait_falls", 64'(cw_falls - f0), 64'd1);

        // Write-protected: back to 5, write, then 5 -> 6 loads only
        set_track(5);
        wait_idle("back_to_5");
        a0 = ack_cnt; w0 = wr_acks;
        pulse_we(1'b1);
        set_track(6);
        wait_idle("wp_step");
        check_eq("wp_acks", 64'(ack_cnt - a0), 64'd13);
        check_eq("wp_no_wr", 64'(wr_acks - w0), 64'd0);
        write_protect = 1'b0;

        // Track change (and an ignored write) during the load of 6
        set_track(5);
        wait_idle("back_to_5b");
        a0 = ack_cnt; w0 = wr_acks;
        set_track(6);
        wait_acks(a0 + 4, "mid_load_4th");
        track = 6'd7;
        track_ram_we = 1'b1;
        model_settle(7, 1'b1);
        tick();
        track_ram_we = 1'b0;
        wait_idle("mid_load");
        check_eq("mid_load_acks", 64'(ack_cnt - a0), 64'd26);
        check_eq("mid_load_no_wr", 64'(wr_acks - w0), 64'd0);

        // Remount while dirty: reload current track, no flush
        a0 = ack_cnt; w0 = wr_acks;
        pulse_we(1'b0);
        pulse_mount();
        wait_idle("remount");
        check_eq("remount_acks", 64'(ack_cnt - a0), 64'd13);
        check_eq("remount_no_wr", 64'(wr_acks - w0), 64'd0);

        // Reset in the middle of a load
        a0 = ack_cnt;
        set_track(10);
        wait_acks(a0 + 5, "rst_mid");
        @(posedge clk_sys); #3;
        host_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_sd_rd", {63'd0, sd_rd}, 64'd0);
        check_eq("rst_mid_cpu_wait", {63'd0, cpu_wait}, 64'd0);
        check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
        repeat (6) @(negedge clk_sys);
        exp_q.delete();
        m_cur = 63; m_dirty = 0; m_pending = 0;
        a0 = ack_cnt;
        model_settle(10, 1'b1);
        @(negedge clk_sys);
        reset_n = 1'b1;
        host_en = 1'b1;
        wait_idle("after_reset");
        check_eq("after_reset_acks", 64'(ack_cnt - a0), 64'd13);

        // No image: track follows silently, no SD traffic
        a0 = ack_cnt;
        tick();
        img_size = 64'd0;
        pulse_we(1'b0);
        set_track(20);
        repeat (10) tick();
        check_eq("noimg_busy", {63'd0, busy}, 64'd0);
        check_eq("noimg_acks", 64'(ack_cnt - a0), 64'd0);
        tick();
        img_size = IMG_BYTES;
        model_settle(20, 1'b1);
        wait_idle("noimg_restore");
        check_eq("noimg_restore_acks", 64'(ack_cnt - a0), 64'd0);

        // Randomized mix of writes, steps and remounts
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: pulse_we(1'($urandom_range(0, 1)));
                1, 2: set_track(int'($urandom_range(0, 63)));
                default: pulse_mount();
            endcase
            write_protect = 1'b0;
            wait_idle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/disk_track_sync.md
DISK_TRACK_SYNC -- requirements
Module: disk_track_sync

Interface
REQ-001 SECTORS_PER_TRACK, 13, SD sectors (512 B) per nibble track.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 track  in  6  track currently selected by the disk controller.
REQ-005 img_mounted  in  1  one-cycle pulse when an image is (re)mounted.
REQ-006 img_size  in  64  image size in bytes; zero means no image.
REQ-007 write_protect  in  1  high: track writes never mark the track dirty.
REQ-008 track_ram_we  in  1  disk controller wrote a byte into track RAM.
REQ-009 sd_lba  out  32  sector address for the SD request.
REQ-010 sd_rd  out  1  SD read request.
REQ-011 sd_wr  out  1  SD write request.
REQ-012 sd_ack  in  1  SD host acknowledge; high for the duration of one sector transfer.
REQ-013 track_sec  out  4  sector index; upper track-RAM address bits during a transfer.
REQ-014 cpu_wait  out  1  stalls the CPU while a flush or load is in progress.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, FLUSH and LOAD.
REQ-017 A dirty flag SHALL set in IDLE when track_ram_we=1 and write_protect=0; it SHALL be ignored in FLUSH and LOAD.
REQ-018 IDLE with a remount pending (img_mounted seen since the last LOAD start), when img_size!=0:
- clear dirty and the pending flag;
- go to LOAD for the current track.
REQ-019 IDLE with track!=cur_track and img_size!=0:
- dirty=1: go to FLUSH for cur_track;
- dirty=0: latch cur_track<=track and go to LOAD.
REQ-020 IDLE with img_size==0: latch cur_track<=track, clear dirty and pending, no SD traffic.
REQ-021 On entry to FLUSH or LOAD:
- sd_lba <= SECTORS_PER_TRACK*tgt, zero-extended to 32 bits, computed exactly with no truncation;
- track_sec <= 0;
- sd_wr (FLUSH) or sd_rd (LOAD) <= 1;
- cpu_wait <= 1.
REQ-022 On each rising edge of sd_ack: sd_lba += 1; if track_sec == SECTORS_PER_TRACK-1, drop the request line in the same cycle.
REQ-023 On each falling edge of sd_ack: track_sec += 1; if the request is already low, the operation is complete.
REQ-024 FLUSH completion: clear dirty, latch cur_track<=track, go to LOAD in the next cycle with cpu_wait held high.
REQ-025 LOAD completion: cpu_wait <= 0, go to IDLE; IDLE re-evaluates track in the next cycle.
REQ-026 A track change or img_mounted during FLUSH/LOAD SHALL NOT abort the operation; it is handled by REQ-018/019 afterwards.
REQ-027 Exactly SECTORS_PER_TRACK ack pulses SHALL complete an operation; track_sec SHALL NOT exceed SECTORS_PER_TRACK.
REQ-028 sd_rd and sd_wr SHALL never be high simultaneously.
REQ-029 Edge detection of sd_ack SHALL use a registered copy, giving one cycle of latency from the ack edge to the output update.

Reset
REQ-030 While reset_n=0:
- state=IDLE;
- sd_rd=sd_wr=cpu_wait=0;
- sd_lba=0, track_sec=0;
- dirty=0, pending=0;
- cur_track=6'h3F, so the first IDLE cycle with an image triggers LOAD.
REQ-031 Reset mid-operation SHALL drop all requests immediately; any partial transfer is abandoned.

Structure
REQ-032 The shared package apple2_disk_pkg SHALL hold the state enum, SECTOR_BYTES=512 and the SECTORS_PER_TRACK default.
REQ-033 The multi-sector ack handshake (REQ-021..023, 027) SHALL be the sub-module sd_sector_seq; disk_track_sync contains only the policy FSM.

Verification
REQ-034 Initial load:
- stimulus: reset, img_size=143360, track=0;
- response: sd_rd rises; 13 acks at sd_lba 0..12; track_sec ends at 13; cpu_wait falls 1 cycle after the 13th ack fall.
REQ-035 Clean step:
- stimulus: track 0->5, dirty=0;
- response: LOAD only; first sd_lba=65, last=77; sd_wr never high.
REQ-036 Dirty step:
- stimulus: track_ram_we pulse, write_protect=0, then track 5->6;
- response: FLUSH at sd_lba 65..77 (sd_wr), then LOAD at 78..90 (sd_rd); cpu_wait continuously high.
REQ-037 Write-protected:
- stimulus: same sequence as REQ-036 with write_protect=1;
- response: no FLUSH; LOAD at 78..90 only.
REQ-038 Track change mid-load:
- stimulus: track changes 6->7 during the 4th ack;
- response: the LOAD of 6 completes (13 acks), then a LOAD of 7 starts at sd_lba 91.
REQ-039 Remount and reset:
- stimulus: img_mounted while dirty;
- response: no FLUSH, reload of the current track.
- stimulus: reset_n low mid-LOAD;
- response: sd_rd=0 and cpu_wait=0 asynchronously.
